// File: rtl/alu_issue_if.sv
// Bundles the ID-side request, ALU drive/response and writeback handshake of the
// execute-stage issue controller.
interface alu_issue_if #(parameter int XLEN = 32);
    logic            id_valid;
    logic            id_ready;
    logic [6:0]      id_opcode;
    logic [2:0]      id_funct3;
    logic            id_funct7b5;
    logic [4:0]      id_rd;
    logic [XLEN-1:0] id_rs1_data;
    logic [XLEN-1:0] id_rs2_data;
    logic [XLEN-1:0] id_imm;
    logic [XLEN-1:0] id_pc;
    logic            flush;
    logic [XLEN-1:0] alu_data1;
    logic [XLEN-1:0] alu_data2;
    logic [3:0]      alu_op;
    logic [XLEN-1:0] alu_result;
    logic            alu_zero;
    logic            alu_sign;
    logic            wb_valid;
    logic            wb_ready;
    logic [XLEN-1:0] wb_data;
    logic [4:0]      wb_rd;
    logic            wb_we;
    logic            wb_illegal;
    logic            br_taken;
    logic [XLEN-1:0] br_target;

    modport master (
        output id_valid, id_opcode, id_funct3, id_funct7b5, id_rd, id_rs1_data,
               id_rs2_data, id_imm, id_pc, flush, alu_result, alu_zero, alu_sign, wb_ready,
        input  id_ready, alu_data1, alu_data2, alu_op, wb_valid, wb_data, wb_rd, wb_we,
               wb_illegal, br_taken, br_target
    );

    modport slave (
        input  id_valid, id_opcode, id_funct3, id_funct7b5, id_rd, id_rs1_data,
               id_rs2_data, id_imm, id_pc, flush, alu_result, alu_zero, alu_sign, wb_ready,
        output id_ready, alu_data1, alu_data2, alu_op, wb_valid, wb_data, wb_rd, wb_we,
               wb_illegal, br_taken, br_target
    );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Execute-stage issue controller: E entry drives the external ALU, W entry holds the
// captured result, flags-derived branch decision and pc+imm target for writeback.
module alu_issue_ctrl #(
    parameter int XLEN = 32
) (
    input logic      clk,
    input logic      rst_n,
    alu_issue_if.slave bus
);
    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_SLL  = 4'd2;
    localparam logic [3:0] ALU_SLT  = 4'd3;
    localparam logic [3:0] ALU_SLTU = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_OR   = 4'd8;
    localparam logic [3:0] ALU_AND  = 4'd9;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam int PAD = XLEN - 5;

    logic            e_valid;
    logic [6:0]      e_opcode;
    logic [2:0]      e_funct3;
    logic            e_funct7b5;
    logic [4:0]      e_rd;
    logic [XLEN-1:0] e_rs1;
    logic [XLEN-1:0] e_rs2;
    logic [XLEN-1:0] e_imm;
    logic [XLEN-1:0] e_pc;

    logic            w_valid;
    logic [XLEN-1:0] w_data;
    logic [4:0]      w_rd;
    logic            w_we;
    logic            w_illegal;
    logic            w_taken;
    logic [XLEN-1:0] w_target;

    logic            e_adv;
    logic            accept;
    logic [XLEN-1:0] dec_d1;
    logic [XLEN-1:0] dec_d2;
    logic [3:0]      dec_op;
    logic            dec_branch;
    logic            dec_illegal;
    logic            dec_we;
    logic            dec_taken;

    function automatic logic [3:0] arith_op(input logic [2:0] f3, input logic f7b5,
                                            input logic allow_sub);
        case (f3)
            3'b000:  arith_op = (allow_sub && f7b5) ? ALU_SUB : ALU_ADD;
            3'b001:  arith_op = ALU_SLL;
            3'b010:  arith_op = ALU_SLT;
            3'b011:  arith_op = ALU_SLTU;
            3'b100:  arith_op = ALU_XOR;
            3'b101:  arith_op = f7b5 ? ALU_SRA : ALU_SRL;
            3'b110:  arith_op = ALU_OR;
            default: arith_op = ALU_AND;
        endcase
    endfunction

    assign e_adv       = e_valid & (~w_valid | bus.wb_ready);
    assign bus.id_ready = ~e_valid | e_adv;
    assign accept      = bus.id_valid & bus.id_ready;

    // The ALU shifts by its whole operand, so shift amounts are trimmed to 5 bits here.
    always_comb begin
        dec_d1      = '0;
        dec_d2      = '0;
        dec_op      = ALU_ADD;
        dec_branch  = 1'b0;
        dec_illegal = 1'b0;
        dec_we      = 1'b0;
        dec_taken   = 1'b0;
        case (e_opcode)
            OPC_OP, OPC_OP_IMM: begin
                dec_d1 = e_rs1;
                dec_d2 = (e_opcode == OPC_OP) ? e_rs2 : e_imm;
                dec_op = arith_op(e_funct3, e_funct7b5, e_opcode == OPC_OP);
                if (e_funct3 == 3'b001 || e_funct3 == 3'b101) begin
                    dec_d2 = {{PAD{1'b0}}, dec_d2[4:0]};
                end
                dec_we = (e_rd != 5'd0);
            end
            OPC_LUI: begin
                dec_d2 = e_imm;
                dec_we = (e_rd != 5'd0);
            end
            OPC_AUIPC: begin
                dec_d1 = e_pc;
                dec_d2 = e_imm;
                dec_we = (e_rd != 5'd0);
            end
            OPC_BRANCH: begin
                dec_d1     = e_rs1;
                dec_d2     = e_rs2;
                dec_branch = 1'b1;
                case (e_funct3)
                    3'b000: begin dec_op = ALU_SUB;  dec_taken = bus.alu_zero;  end
                    3'b001: begin dec_op = ALU_SUB;  dec_taken = ~bus.alu_zero; end
                    3'b100: begin dec_op = ALU_SLT;  dec_taken = ~bus.alu_zero; end
                    3'b101: begin dec_op = ALU_SLT;  dec_taken = bus.alu_zero;  end
                    3'b110: begin dec_op = ALU_SLTU; dec_taken = ~bus.alu_zero; end
                    3'b111: begin dec_op = ALU_SLTU; dec_taken = bus.alu_zero;  end
                    default: dec_illegal = 1'b1;
                endcase
            end
            default: dec_illegal = 1'b1;
        endcase
    end

    assign bus.alu_data1 = dec_d1;
    assign bus.alu_data2 = dec_d2;
    assign bus.alu_op    = dec_op;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_valid    <= 1'b0;
            e_opcode   <= '0;
            e_funct3   <= '0;
            e_funct7b5 <= 1'b0;
            e_rd       <= '0;
            e_rs1      <= '0;
            e_rs2      <= '0;
            e_imm      <= '0;
            e_pc       <= '0;
        end else begin
            if (accept) begin
                e_opcode   <= bus.id_opcode;
                e_funct3   <= bus.id_funct3;
                e_funct7b5 <= bus.id_funct7b5;
                e_rd       <= bus.id_rd;
                e_rs1      <= bus.id_rs1_data;
                e_rs2      <= bus.id_rs2_data;
                e_imm      <= bus.id_imm;
                e_pc       <= bus.id_pc;
            end
            // Flush discards whatever is accepted in the same cycle.
            if (bus.flush)   e_valid <= 1'b0;
            else if (accept) e_valid <= 1'b1;
            else if (e_adv)  e_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_valid   <= 1'b0;
            w_data    <= '0;
            w_rd      <= '0;
            w_we      <= 1'b0;
            w_illegal <= 1'b0;
            w_taken   <= 1'b0;
            w_target  <= '0;
        end else begin
            if (e_adv && !bus.flush) begin
                w_data    <= (dec_branch || dec_illegal) ? '0 : bus.alu_result;
                w_rd      <= e_rd;
                w_we      <= dec_we;
                w_illegal <= dec_illegal;
                w_taken   <= dec_taken;
                w_target  <= e_pc + e_imm;
            end
            if (bus.flush)        w_valid <= 1'b0;
            else if (e_adv)       w_valid <= 1'b1;
            else if (bus.wb_ready) w_valid <= 1'b0;
        end
    end

    assign bus.wb_valid   = w_valid;
    assign bus.wb_data    = w_data;
    assign bus.wb_rd      = w_rd;
    assign bus.wb_we      = w_we;
    assign bus.wb_illegal = w_illegal;
    assign bus.br_taken   = w_taken;
    assign bus.br_target  = w_target;
endmodule
